// File: rtl/impulse_frame_rx_if.sv
// Bus bundle for impulse_frame_rx: serial link inputs, register-file read port and word/status outputs.
interface impulse_frame_rx_if #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned NUM_CH = 8,
    parameter int unsigned ADDR_W = 4
);
    logic              serial_in;
    logic              sl_in;
    logic [ADDR_W-1:0] addr_in;
    logic              ovf_global_in;
    logic              ovf_rtc_in;
    logic [ADDR_W-1:0] rd_addr;
    logic [WIDTH-1:0]  rd_data;
    logic              word_valid;
    logic [ADDR_W-1:0] word_ch;
    logic [WIDTH-1:0]  word_data;
    logic              frame_err;
    logic              addr_err;
    logic [NUM_CH-1:0] ovf_flags;
    logic              rtc_seen;

    modport master (
        output serial_in, sl_in, addr_in, ovf_global_in, ovf_rtc_in, rd_addr,
        input  rd_data, word_valid, word_ch, word_data, frame_err, addr_err, ovf_flags, rtc_seen
    );

    modport slave (
        input  serial_in, sl_in, addr_in, ovf_global_in, ovf_rtc_in, rd_addr,
        output rd_data, word_valid, word_ch, word_data, frame_err, addr_err, ovf_flags, rtc_seen
    );
endinterface

// File: rtl/impulse_frame_rx.sv
// Deserializes SL-framed counter words into a per-channel register file with overflow capture.
// Optional macro RX_PARITY_EN appends one even-parity bit to each frame.
module impulse_frame_rx #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned NUM_CH = 8,
    parameter int unsigned ADDR_W = 4
) (
    input logic               clk,
    input logic               reset,
    impulse_frame_rx_if.slave bus
);
`ifdef RX_PARITY_EN
    localparam int unsigned FRAME_BITS = WIDTH + 1;
`else
    localparam int unsigned FRAME_BITS = WIDTH;
`endif
    localparam int unsigned CNT_W = $clog2(FRAME_BITS + 1);
    localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, WAIT} state_t;

    state_t            state;
    state_t            state_next;
    logic              start_c;
    logic              shift_c;
    logic              last_c;
    logic              short_c;
    logic              par_ok_c;
    logic              wr_ok_c;
    logic              rd_ok_c;

    logic [WIDTH-1:0]  shreg;
    logic [CNT_W-1:0]  bitcnt;
    logic [ADDR_W-1:0] addr_lat;
    logic              rtc_acc;
    logic              ovf_last;
    logic              cmp_pend;
    logic [WIDTH-1:0]  regs [NUM_CH];

    assign wr_ok_c = ({1'b0, addr_lat} < (ADDR_W + 1)'(NUM_CH));
    assign rd_ok_c = ({1'b0, bus.rd_addr} < (ADDR_W + 1)'(NUM_CH));

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        start_c    = 1'b0;
        shift_c    = 1'b0;
        last_c     = 1'b0;
        short_c    = 1'b0;
        case (state)
            IDLE: begin
                if (!bus.sl_in) begin
                    start_c    = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (bus.sl_in) begin
                    short_c    = 1'b1;
                    state_next = IDLE;
                end else begin
                    shift_c = 1'b1;
                    if (bitcnt == CNT_W'(FRAME_BITS - 1)) begin
                        last_c     = 1'b1;
                        state_next = WAIT;
                    end
                end
            end
            WAIT: begin
                if (bus.sl_in) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

`ifdef RX_PARITY_EN
    // Running XOR over every received bit, parity bit included; even parity leaves it 0.
    logic par_acc;
    always_ff @(posedge clk) begin
        if (reset)        par_acc <= 1'b0;
        else if (start_c) par_acc <= bus.serial_in;
        else if (shift_c) par_acc <= par_acc ^ bus.serial_in;
    end
    assign par_ok_c = ~par_acc;
`else
    assign par_ok_c = 1'b1;
`endif

    // Completion is applied one edge after the last bit, from state latched at that bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            shreg          <= '0;
            bitcnt         <= '0;
            addr_lat       <= '0;
            rtc_acc        <= 1'b0;
            ovf_last       <= 1'b0;
            cmp_pend       <= 1'b0;
            bus.word_valid <= 1'b0;
            bus.frame_err  <= 1'b0;
            bus.addr_err   <= 1'b0;
            bus.word_ch    <= '0;
            bus.word_data  <= '0;
            bus.ovf_flags  <= '0;
            bus.rtc_seen   <= 1'b0;
            bus.rd_data    <= '0;
            for (int i = 0; i < int'(NUM_CH); i++) regs[i] <= '0;
        end else begin
            cmp_pend       <= last_c;
            bus.word_valid <= 1'b0;
            bus.frame_err  <= 1'b0;
            bus.addr_err   <= 1'b0;

            if (start_c) begin
                shreg    <= WIDTH'(bus.serial_in);
                bitcnt   <= CNT_W'(1);
                addr_lat <= bus.addr_in;
                rtc_acc  <= bus.ovf_rtc_in;
            end

            if (shift_c) begin
                // The parity bit, when present, arrives after WIDTH data bits and is not stored.
                if (bitcnt < CNT_W'(WIDTH)) shreg <= {shreg[WIDTH-2:0], bus.serial_in};
                bitcnt  <= bitcnt + CNT_W'(1);
                rtc_acc <= rtc_acc | bus.ovf_rtc_in;
                if (last_c) ovf_last <= bus.ovf_global_in;
            end

            if (short_c) begin
                bitcnt        <= '0;
                bus.frame_err <= 1'b1;
            end

            if (cmp_pend) begin
                bitcnt       <= '0;
                bus.rtc_seen <= bus.rtc_seen | rtc_acc;
                if (!par_ok_c) begin
                    bus.frame_err <= 1'b1;
                end else begin
                    bus.word_data <= shreg;
                    bus.word_ch   <= addr_lat;
                    if (wr_ok_c) begin
                        regs[addr_lat[CH_W-1:0]]          <= shreg;
                        bus.ovf_flags[addr_lat[CH_W-1:0]] <= ovf_last;
                        bus.word_valid                    <= 1'b1;
                    end else begin
                        bus.addr_err <= 1'b1;
                    end
                end
            end

            bus.rd_data <= rd_ok_c ? regs[bus.rd_addr[CH_W-1:0]] : '0;
        end
    end
endmodule

// File: doc/impulse_frame_rx.md
Name: impulse_frame_rx

Overview:
Receive end of the impulse-counter serial readout link. Deserializes the counter's serial data stream, framed by shift/load (SL) and a 4-bit channel address, into WIDTH-bit words. Stores the words in a per-channel register file that downstream logic reads.
- Sits beside the counter top on the same clock domain.
- Captures the overflow strobes alongside each word.

Parameters:
WIDTH, 16, bits per counter word, sent MSB first
NUM_CH, 8, channels stored; addresses >= NUM_CH are rejected
ADDR_W, 4, width of channel address bus

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
serial_in  in  1  serial data bit from counter
sl_in  in  1  1 = load phase (idle/framing), 0 = shift phase (one data bit per clk)
addr_in  in  ADDR_W  channel address of the current frame
ovf_global_in  in  1  counter global overflow flag
ovf_rtc_in  in  1  RTC overflow flag
rd_addr  in  ADDR_W  register-file read address
rd_data  out  WIDTH  registered read data
word_valid  out  1  1-cycle pulse: word stored
word_ch  out  ADDR_W  channel of last completed word
word_data  out  WIDTH  last completed word
frame_err  out  1  1-cycle pulse: short frame (or parity fail)
addr_err  out  1  1-cycle pulse: complete word with addr >= NUM_CH
ovf_flags  out  NUM_CH  per-channel overflow seen with last stored word
rtc_seen  out  1  sticky: ovf_rtc_in high during any completed frame

Behaviour:
- Clock is clk. Reset is synchronous and active-high on reset.
- Reset values:
  - State returns to IDLE.
  - Shift register and bit counter clear.
  - Register file clears to 0.
  - All outputs go to 0.
- Reset mid-frame aborts the frame with no error pulse.
- FSM states: IDLE, SHIFT, WAIT.
- IDLE:
  - sl_in=1: stay in IDLE.
  - sl_in=0: sample serial_in as bit WIDTH-1, latch addr_in, set bitcnt=1, go to SHIFT.
- SHIFT:
  - Each cycle with sl_in=0: shift serial_in in (left shift, LSB entry) and increment bitcnt.
  - When the bit making bitcnt==WIDTH is sampled, go to WAIT and perform a completion on the next edge.
- WAIT:
  - Ignores serial_in while sl_in=0.
  - sl_in=1 returns to IDLE.
  - A new frame requires at least one cycle of sl_in=1.
- Short frame: sl_in=1 in SHIFT with bitcnt<WIDTH.
  - Discard the partial word.
  - Pulse frame_err the next cycle.
  - Go to IDLE. The register file is unchanged.
- Completion, all effects visible one cycle after the last bit is sampled:
  - word_data/word_ch update.
  - If latched addr < NUM_CH: regfile[addr] is written, ovf_flags[addr] = ovf_global_in sampled at the last bit, and word_valid pulses.
  - Otherwise: no write, addr_err pulses, word_valid stays 0.
  - rtc_seen is set if ovf_rtc_in was 1 on any cycle of the frame. It clears only on reset.
- Frame timing: WIDTH=16 completes in 16 shift cycles. Back-to-back frames need SL-high ≥1 cycle, so peak throughput is one word per WIDTH+1 cycles.
- Read port:
  - rd_data = regfile[rd_addr], registered, 1-cycle latency.
  - rd_addr >= NUM_CH returns 0.
  - A same-cycle read and write to the same address returns the old value; the new value appears on the following read.
- addr_in is sampled only at frame start; changes mid-frame are ignored.
- word_valid, frame_err and addr_err are mutually exclusive in any cycle.

Optional Feature:
RX_PARITY_EN:
- Defined:
  - Frame is WIDTH+1 bits: data MSB-first, then one even-parity bit (XOR of all WIDTH+1 bits = 0).
  - WAIT is entered after bit WIDTH+1.
  - On parity mismatch: word discarded, frame_err pulses instead of word_valid/addr_err, ovf_flags unchanged.
  - A short frame is sl_in=1 before WIDTH+1 bits.
- Undefined: frame is WIDTH bits and no parity check exists.

Test Plan:
1. Reset, then a frame ch=3 with data 16'hA5C3 (16 shift cycles, SL high before and after) -> word_valid pulse exactly 1 cycle after the 16th bit, word_ch=3, word_data=A5C3, rd_addr=3 gives rd_data=A5C3 next cycle; all other channels read 0.
2. Back-to-back frames ch0=0x0001, ch7=0xFFFF with a single SL-high cycle between them -> both stored, two word_valid pulses 17 cycles apart.
3. Frame ch=2 aborted by SL high after 9 bits -> frame_err pulse, no word_valid, regfile[2] keeps its prior value; the next full frame ch=2 = 0x1234 is stored correctly.
4. Frame with addr_in=9 (NUM_CH=8), data 0xBEEF -> addr_err pulse, no write anywhere, word_data=BEEF.
5. Frame ch=5 with ovf_global_in=1 at the last bit and ovf_rtc_in pulsed mid-frame -> ovf_flags[5]=1, rtc_seen=1; a later frame ch=5 with ovf low clears ovf_flags[5] while rtc_seen stays 1. Reset asserted mid-frame -> all outputs 0, no pulses.
6. RX_PARITY_EN: frame 0x00FF with parity 0 -> stored; same data with parity 1 -> frame_err, regfile unchanged.
